serial_adder: RTL
=================

# serial_adder

Bit-serial ripple adder that adds two WIDTH-bit operands LSB-first, one bit per clock, using a single full-adder cell built from two `half_adder` instances plus an OR gate, with the carry held in a flip-flop between cycles. It sits directly downstream of the half-adder cell and is the first sequential consumer of it in the adders lab set. It is the area-minimal counterpart to the parallel ripple-carry adder: one adder cell, WIDTH+1 cycles per operation, start/busy/done handshake.

## Interface
- `WIDTH`, default 8: operand and sum width in bits. Legal range is WIDTH ≥ 2.

Ports:
- `clk`  input  1: single clock; all state updates on the rising edge.
- `rst`  input  1: synchronous reset, active-high.
- `start`  input  1: request to begin an addition. Sampled only in IDLE.
- `a`  input  WIDTH: operand A, captured on the accepted start.
- `b`  input  WIDTH: operand B, captured on the accepted start.
- `cin`  input  1: carry-in, captured on the accepted start.
- `busy`  output  1: high while bits are being processed (SHIFT state).
- `done`  output  1: one-cycle pulse; `sum` and `cout` are valid from this cycle onward.
- `sum`  output  WIDTH: registered result, held until the next `done`.
- `cout`  output  1: registered carry-out, held until the next `done`.

## Operation
- **Interface decision:** one clock (`clk`); reset `rst` is synchronous and active-high.
- **Internal registers:**
  - operand shift registers `a_sh` and `b_sh` (WIDTH bits each);
  - sum shift register `s_sh` (WIDTH bits);
  - carry flip-flop `c_ff`;
  - bit counter `cnt` (clog2(WIDTH) bits);
  - state register.
- **Full-adder cell:**
  - HA1 computes (`a_sh[0]`, `b_sh[0]`) → (p, g1).
  - HA2 computes (p, `c_ff`) → (s, g2).
  - Carry is g1 | g2.
  - No other adder logic is permitted.
- **State IDLE:** `busy`=0 and `done`=0. If `start`=1:
  - `a_sh`←a, `b_sh`←b, `c_ff`←cin, `cnt`←0, `s_sh`←0;
  - go to SHIFT.
- **State SHIFT:** `busy`=1. Each cycle:
  - `s_sh`←{s, `s_sh`[WIDTH-1:1]};
  - `a_sh` and `b_sh` shift right by 1, filling with 0;
  - `c_ff`←carry;
  - `cnt`←`cnt`+1.
  - When `cnt`==WIDTH-1, that cycle processes the MSB. At that edge `sum`←{s, `s_sh`[WIDTH-1:1]} and `cout`←carry, then go to DONE.
- **State DONE:** `done`=1 and `busy`=0 for exactly one cycle, then go to IDLE unconditionally. `start` is ignored in DONE.
- **Ignored inputs:**
  - `start` in SHIFT or DONE has no effect and is not queued.
  - Changes to `a`, `b` or `cin` after the accepted start do not affect the result.
- **Arithmetic:** {`cout`, `sum`} = a + b + cin, exact modulo 2^(WIDTH+1). Operands are unsigned; two's-complement results are identical in `sum`.
- **Reset (any state, including mid-SHIFT):** on the next edge the block goes to IDLE, `busy`=0, `done`=0, `sum`=0, `cout`=0, and all internal registers are cleared. The partial result is discarded.
- **Reset priority:** `rst` and `start` high in the same cycle: reset wins and the start is dropped.

## Timing
- **Reset values:** `busy`=0, `done`=0, `sum`=0, `cout`=0.
- **Latency:** for start sampled at edge k:
  - `busy` is high in cycles k+1 … k+WIDTH;
  - `done` is high in cycle k+WIDTH+1;
  - `sum` and `cout` update at edge k+WIDTH.
- **Throughput:** one addition per WIDTH+2 cycles. The earliest next accepted start is at edge k+WIDTH+2 (IDLE).
- **Output hold:** `sum` and `cout` keep their value through IDLE and during the next operation's SHIFT phase. They change only at the completing edge or on reset.
- **Glitch-free outputs:** `busy` and `done` are decoded directly from the state register (or registered); no combinational path from `start` to any output.
- **Critical path:** two HA levels plus the OR gate into `c_ff`, independent of WIDTH.

## Test plan
- **Basic add:** WIDTH=8, a=0x5A, b=0x33, cin=0, start pulsed one cycle → `busy` high 8 cycles, `done` pulse 9 cycles after the start edge, `sum`=0x8D, `cout`=0.
- **Full carry ripple:** a=0xFF, b=0x01, cin=0 → `sum`=0x00, `cout`=1. Then a=0xFF, b=0xFF, cin=1 → `sum`=0xFF, `cout`=1.
- **Start while busy:** start a=0x10, b=0x20; pulse `start` with a=0x01, b=0x01 in the 3rd SHIFT cycle, and change `a` mid-operation → exactly one `done`, `sum`=0x30, no second operation begins.
- **Reset mid-operation:** start a=0x0F, b=0x0F; assert `rst` during the 4th SHIFT cycle → next cycle `busy`=0, `done`=0, `sum`=0, `cout`=0, no `done` pulse afterwards; a following start a=0x02, b=0x03 completes with `sum`=0x05.
- **Back-to-back operations:** hold `start`=1 continuously with a=0x80, b=0x80, cin=0 → operations accepted every 10 cycles, each giving `sum`=0x00 and `cout`=1. `start` in DONE is not accepted; the results of the previous operation hold until the next `done`.
- **Randomized check:** 1000 random a, b, cin at WIDTH=8 and WIDTH=16 → {`cout`, `sum`} matches a+b+cin on every `done`.

Source files
------------

// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell (two half adders plus an OR) processes
// one operand bit per clock, LSB first, with the carry held in a flip-flop.

module half_adder (
  input  logic x,
  input  logic y,
  output logic s,
  output logic c
);
  assign s = x ^ y;
  assign c = x & y;
endmodule

module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] s_sh_q, s_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             c_ff_q, c_ff_d;
  logic             cout_q, cout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic p_s, g1_s, s_s, g2_s, carry_s;

  // Full-adder cell: the only adder logic in the datapath.
  half_adder u_ha1 (.x(a_sh_q[0]), .y(b_sh_q[0]), .s(p_s), .c(g1_s));
  half_adder u_ha2 (.x(p_s),       .y(c_ff_q),    .s(s_s), .c(g2_s));
  assign carry_s = g1_s | g2_s;

  // State register and datapath flops; reset clears everything and beats start.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_sh_q  <= {WIDTH{1'b0}};
      b_sh_q  <= {WIDTH{1'b0}};
      s_sh_q  <= {WIDTH{1'b0}};
      sum_q   <= {WIDTH{1'b0}};
      cnt_q   <= {CW{1'b0}};
      c_ff_q  <= 1'b0;
      cout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      s_sh_q  <= s_sh_d;
      sum_q   <= sum_d;
      cnt_q   <= cnt_d;
      c_ff_q  <= c_ff_d;
      cout_q  <= cout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state and datapath update; handshake flags follow the next state.
  always_comb begin
    state_d = state_q;
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    s_sh_d  = s_sh_q;
    sum_d   = sum_q;
    cnt_d   = cnt_q;
    c_ff_d  = c_ff_q;
    cout_d  = cout_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          a_sh_d  = a;
          b_sh_d  = b;
          c_ff_d  = cin;
          cnt_d   = {CW{1'b0}};
          s_sh_d  = {WIDTH{1'b0}};
          state_d = SHIFT;
        end else begin
          state_d = IDLE;
        end
      end
      SHIFT: begin
        s_sh_d = {s_s, s_sh_q[WIDTH-1:1]};
        a_sh_d = {1'b0, a_sh_q[WIDTH-1:1]};
        b_sh_d = {1'b0, b_sh_q[WIDTH-1:1]};
        c_ff_d = carry_s;
        cnt_d  = cnt_q + CNT_ONE;
        if (cnt_q == CNT_LAST) begin
          sum_d   = {s_s, s_sh_q[WIDTH-1:1]};
          cout_d  = carry_s;
          state_d = DONE;
        end else begin
          state_d = SHIFT;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d == SHIFT);
    done_d = (state_d == DONE);
  end

  assign busy = busy_q;
  assign done = done_q;
  assign sum  = sum_q;
  assign cout = cout_q;
endmodule
